// File: rtl/torture_pkg.sv
// Shared types and constants for the torture array stress block.
// Holds the FSM state encoding and the MISR defaults.
package torture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          MISR_W        = 32;
    localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_MISR_SEED = 32'hFFFFFFFF;

    // One MISR step: shift left, fold in the polynomial, absorb the tails.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] cur,
        input logic [MISR_W-1:0] poly,
        input logic [MISR_W-1:0] din
    );
        return {cur[MISR_W-2:0], 1'b0}
             ^ (cur[MISR_W-1] ? poly : '0)
             ^ din;
    endfunction

endpackage

// File: rtl/torture_chain.sv
// One toggle chain: XOR3 chaotic or shift-only propagation of a toggle bit.
// Cells and toggle hold unless enabled; clr wipes them to zero.
module torture_chain #(
    parameter int CHAIN_LEN = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic mode,
    input  logic en,
    input  logic clr,
    output logic tail
);

    (* keep = "true" *) logic [CHAIN_LEN-1:0] cells;
    (* keep = "true" *) logic                 tgl;
    logic [CHAIN_LEN-1:0] nxt;

    // Next chain value for the selected propagation mode.
    always_comb begin
        nxt    = cells;
        nxt[0] = tgl;
        if (mode) begin
            for (int i = 1; i < CHAIN_LEN; i++) begin
                nxt[i] = cells[i-1];
            end
        end else begin
            nxt[1] = cells[0] ^ tgl;
            nxt[2] = cells[1] ^ cells[0] ^ tgl;
            for (int i = 3; i < CHAIN_LEN; i++) begin
                nxt[i] = cells[i-3] ^ cells[i-2] ^ cells[i-1];
            end
        end
    end

    // Chain and toggle registers: clear wins, otherwise advance when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells <= '0;
            tgl   <= 1'b0;
        end else if (clr) begin
            cells <= '0;
            tgl   <= 1'b0;
        end else if (en) begin
            cells <= nxt;
            tgl   <= ~tgl;
        end
    end

    assign tail = cells[CHAIN_LEN-1];

endmodule

// File: rtl/torture_array.sv
// Array of toggle chains with a staggered enable ramp, a timed run phase
// and a MISR that compresses all chain tails into one signature.
module torture_array
    import torture_pkg::*;
#(
    parameter int          NUM_CHAINS = 4,
    parameter int          CHAIN_LEN  = 1024,
    parameter int          RAMP_STEP  = 256,
    parameter logic [31:0] MISR_POLY  = DEF_MISR_POLY,
    parameter logic [31:0] MISR_SEED  = DEF_MISR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [31:0] run_len,
    output logic        busy,
    output logic        done,
    output logic [5:0]  active_chains,
    output logic [31:0] signature,
    output logic        led
);

    localparam int SW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

    state_t              state;
    state_t              state_d;
    logic                mode_q;
    logic [31:0]         run_len_q;
    logic [5:0]          active;
    logic [SW-1:0]       step_cnt;
    logic [31:0]         run_cnt;
    logic [MISR_W-1:0]   misr;
    logic [NUM_CHAINS-1:0] tails;
    logic [NUM_CHAINS-1:0] en;
    logic [MISR_W-1:0]   tails_pad;
    logic                idle_or_done;
    logic                start_go;
    logic                step_last;
    logic                active_full;
    logic                clr;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign start_go     = start && !abort && idle_or_done;
    assign step_last    = (step_cnt == SW'(RAMP_STEP - 1));
    assign active_full  = (active == 6'(NUM_CHAINS));
    assign clr          = abort || start_go;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; abort overrides everything, start only from rest.
    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) state_d = RAMP;
                end
                RAMP: begin
                    if (step_last && active_full) begin
                        state_d = (run_len_q == 32'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if ((run_cnt + 32'd1) == run_len_q) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Run parameters, ramp step counter, enabled-chain count, run counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            run_len_q <= '0;
            active    <= '0;
            step_cnt  <= '0;
            run_cnt   <= '0;
        end else if (abort) begin
            active    <= '0;
            step_cnt  <= '0;
            run_cnt   <= '0;
        end else if (start_go) begin
            mode_q    <= mode;
            run_len_q <= run_len;
            active    <= 6'd1;
            step_cnt  <= '0;
        end else if (state == RAMP) begin
            if (step_last) begin
                step_cnt <= '0;
                if (!active_full) begin
                    active <= active + 6'd1;
                end else begin
                    run_cnt <= '0;
                end
            end else begin
                step_cnt <= step_cnt + SW'(1);
            end
        end else if (state == RUN) begin
            run_cnt <= run_cnt + 32'd1;
        end
    end

    // Zero-extend the chain tails to the MISR width.
    always_comb begin
        tails_pad                 = '0;
        tails_pad[NUM_CHAINS-1:0] = tails;
    end

    // MISR: seeded on start, compresses tails while busy, holds on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr <= '0;
        end else if (!abort) begin
            if (start_go) begin
                misr <= MISR_SEED;
            end else if (busy) begin
                misr <= misr_next(misr, MISR_POLY, tails_pad);
            end
        end
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        assign en[c] = busy && !abort && (6'(c) < active);

        torture_chain #(
            .CHAIN_LEN (CHAIN_LEN)
        ) u_chain (
            .clk  (clk),
            .rst  (rst),
            .mode (mode_q),
            .en   (en[c]),
            .clr  (clr),
            .tail (tails[c])
        );
    end

    assign busy          = (state == RAMP) || (state == RUN);
    assign done          = (state == DONE);
    assign active_chains = active;
    assign signature     = misr;
    assign led           = ^tails;

endmodule

// File: tb/tb_torture_array.sv
// Self-checking bench for torture_array (4 chains, 16 cells, ramp step 8).
// Signatures come from a cycle-by-cycle behavioural model of the chains.
module tb_torture_array;

    localparam int          NC   = 4;
    localparam int          CL   = 16;
    localparam int          RS   = 8;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        mode;
    logic [31:0] run_len;
    logic        busy;
    logic        done;
    logic [5:0]  active_chains;
    logic [31:0] signature;
    logic        led;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    torture_array #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL),
        .RAMP_STEP  (RS),
        .MISR_POLY  (POLY),
        .MISR_SEED  (SEED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .mode          (mode),
        .run_len       (run_len),
        .busy          (busy),
        .done          (done),
        .active_chains (active_chains),
        .signature     (signature),
        .led           (led)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signature after n busy cycles, plus the final XOR of chain tails.
    function automatic logic [31:0] model(input bit m, input int n,
                                          output bit ledv);
        bit [CL-1:0] ch[NC];
        bit          tg[NC];
        bit [CL-1:0] nx;
        bit [31:0]   t;
        logic [31:0] s;
        int          act;
        s = SEED;
        for (int c = 0; c < NC; c++) begin
            ch[c] = '0;
            tg[c] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            act = k / RS + 1;
            if (act > NC) act = NC;
            t = '0;
            for (int c = 0; c < NC; c++) t[c] = ch[c][CL-1];
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ t;
            for (int c = 0; c < act; c++) begin
                nx    = ch[c];
                nx[0] = tg[c];
                if (m) begin
                    for (int i = 1; i < CL; i++) nx[i] = ch[c][i-1];
                end else begin
                    nx[1] = ch[c][0] ^ tg[c];
                    nx[2] = ch[c][1] ^ ch[c][0] ^ tg[c];
                    for (int i = 3; i < CL; i++)
                        nx[i] = ch[c][i-3] ^ ch[c][i-2] ^ ch[c][i-1];
                end
                ch[c] = nx;
                tg[c] = ~tg[c];
            end
        end
        ledv = 1'b0;
        for (int c = 0; c < NC; c++) ledv ^= ch[c][CL-1];
        return s;
    endfunction

    task automatic do_start(input bit m, input int len);
        mode    = m;
        run_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Full run from start; checks done latency, signature and led.
    task automatic run_check(input bit m, input int len, input string nm,
                             output logic [31:0] sig);
        int          t;
        bit          el;
        logic [31:0] es;
        do_start(m, len);
        t = 1;
        while (!done && t < 40 + len) begin
            tick();
            t++;
        end
        total++;
        if (t !== 33 + len) begin
            bad++;
            $display("FAIL %s_done_cycle: got %0d want %0d", nm, t, 33 + len);
        end
        es = model(m, 32 + len, el);
        total++;
        if (signature !== es) begin
            bad++;
            $display("FAIL %s_sig: got %h want %h", nm, signature, es);
        end
        total++;
        if (led !== el) begin
            bad++;
            $display("FAIL %s_led: got %b want %b", nm, led, el);
        end
        sig = signature;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        mode    = 1'b0;
        run_len = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({busy, done, active_chains, signature, led} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b%b %0d %h %b want all zero",
                     busy, done, active_chains, signature, led);
        end
    endtask

    task automatic test_ramp_timing();
        int          ea;
        bit          el;
        logic [31:0] es;
        do_start(1'b0, 100);
        for (int t = 1; t <= 133; t++) begin
            if (t > 1) tick();
            if (t <= 132) begin
                ea = (t - 1) / RS + 1;
                if (ea > NC) ea = NC;
                total++;
                if (active_chains !== 6'(ea)) begin
                    bad++;
                    $display("FAIL ramp_active_t%0d: got %0d want %0d",
                             t, active_chains, ea);
                end
            end
            total++;
            if (busy !== (t < 133) || done !== (t == 133)) begin
                bad++;
                $display("FAIL ramp_busy_done_t%0d: got %b%b want %b%b",
                         t, busy, done, t < 133, t == 133);
            end
        end
        es = model(1'b0, 132, el);
        total++;
        if (signature !== es) begin
            bad++;
            $display("FAIL ramp_sig: got %h want %h", signature, es);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(1'b1, 100);
        repeat (49) tick();
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, active_chains, signature, led} !== '0) begin
            bad++;
            $display("FAIL midrun_reset: got %b%b %0d %h %b want all zero",
                     busy, done, active_chains, signature, led);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrun_idle: got %b%b want 00", busy, done);
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] s;
        run_check(1'b0, 0, "zero_len", s);
    endtask

    task automatic test_repeat();
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] e0;
        bit          el;
        run_check(1'b0, 500, "rep_a", s0);
        run_check(1'b0, 500, "rep_b", s1);
        run_check(1'b1, 500, "rep_shift", s2);
        e0 = model(1'b0, 532, el);
        total++;
        if (s2 === e0) begin
            bad++;
            $display("FAIL mode_differs: got %h want not %h", s2, e0);
        end
    endtask

    task automatic test_abort();
        bit          m;
        bit          el;
        logic [31:0] es;
        m = 1'($urandom_range(0, 1));
        do_start(m, 100);
        repeat (11) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        es = model(m, 11, el);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || active_chains !== 6'd0
            || led !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: got %b%b %0d %b want 00 0 0",
                     busy, done, active_chains, led);
        end
        total++;
        if (signature !== es) begin
            bad++;
            $display("FAIL abort_sig: got %h want %h", signature, es);
        end
        tick();
        total++;
        if (busy !== 1'b0 || signature !== es) begin
            bad++;
            $display("FAIL abort_hold: got %b %h want 0 %h",
                     busy, signature, es);
        end
    endtask

    task automatic test_start_in_run();
        int          t;
        bit          m;
        bit          el;
        logic [31:0] es;
        logic [31:0] s;
        m = 1'($urandom_range(0, 1));
        do_start(m, 20);
        repeat (39) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 41;
        while (!done && t < 60) begin
            tick();
            t++;
        end
        total++;
        if (t !== 53) begin
            bad++;
            $display("FAIL run_start_done: got %0d want 53", t);
        end
        es = model(m, 52, el);
        total++;
        if (signature !== es) begin
            bad++;
            $display("FAIL run_start_sig: got %h want %h", signature, es);
        end
        do_start(~m, 5);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || active_chains !== 6'd1
            || signature !== SEED) begin
            bad++;
            $display("FAIL done_restart: got %b%b %0d %h want 01 1 %h",
                     done, busy, active_chains, signature, SEED);
        end
        t = 1;
        while (!done && t < 50) begin
            tick();
            t++;
        end
        es = model(~m, 37, el);
        total++;
        if (t !== 38 || signature !== es) begin
            bad++;
            $display("FAIL done_restart_run: got %0d %h want 38 %h",
                     t, signature, es);
        end
    endtask

    task automatic test_random();
        logic [31:0] s;
        for (int k = 0; k < 6; k++) begin
            run_check(1'($urandom_range(0, 1)), $urandom_range(0, 40),
                      $sformatf("rnd%0d", k), s);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_timing();
        test_reset_mid_run();
        test_zero_len();
        test_repeat();
        test_abort();
        test_start_in_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
